sram_responder: RTL and testbench



---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_half_array.sv | 32 +++
 rtl/sram_responder.sv | 123 ++++++++++++
 tb/tb_sram_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and address-translation constants for the SRAM responder.
// Requests are 32-bit words carried through the array as two 16-bit halves.
package sram_pkg;

   localparam int HALF_W     = 16;
   localparam int WORD_W     = 32;
   localparam int BYTE_OFF_W = 2;   // byte-within-word bits of an address

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Word offset of a byte address relative to the array base.
   function automatic logic [WORD_W-1:0] word_offset(input logic [WORD_W-1:0] addr,
                                                     input logic [WORD_W-1:0] base);
      logic [WORD_W-1:0] diff;
      diff = addr - base;
      return diff >> BYTE_OFF_W;
   endfunction

endpackage

// File: rtl/sram_half_array.sv
// Half-word storage: synchronous write, read data registered on the access edge.
// No reset on the storage; read data holds until the next read access.
module sram_half_array
   import sram_pkg::*;
#(
   parameter int DEPTH = 128,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [HALF_W-1:0] wdata_i,
   output logic [HALF_W-1:0] rdata_o
);

   logic [HALF_W-1:0] mem_q [DEPTH];
   logic [HALF_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Word-request responder: each 32-bit access is two 16-bit half accesses with
// WAIT_CYCLES wait states each, completed by a one-cycle ready pulse.
module sram_responder
   import sram_pkg::*;
#(
   parameter int MEM_WORDS   = 64,
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] address,
   input  logic [WORD_W-1:0] write_data,
   output logic [WORD_W-1:0] read_data,
   output logic              ready,
   output logic              error
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam logic [WORD_W-1:0] BASE     = WORD_W'(BASE_ADDR);
   localparam logic [WORD_W-1:0] LIMIT    = WORD_W'(MEM_WORDS);

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                op_wr_q;
   logic                err_q;
   logic [IDX_W-1:0]    idx_q;
   logic [WORD_W-1:0]   wdata_q;
   logic [HALF_W-1:0]   lo_hold_q;
   logic [WORD_W-1:0]   read_data_q;

   logic [WORD_W-1:0]   word_off;
   logic                reject;
   logic                arr_en;
   logic                arr_hi;
   logic [HALF_W-1:0]   arr_wdata;
   logic [HALF_W-1:0]   arr_rdata;

   always_comb begin
      word_off = word_offset(address, BASE);
      reject   = (rd_en && wr_en) || (address < BASE) ||
                 (address[BYTE_OFF_W-1:0] != '0) || (word_off >= LIMIT);
   end

   // Array strobes come from registered state only; reset blocks a pending access.
   always_comb begin
      arr_hi    = (state_q == S_HIGH);
      arr_en    = !rst && (state_q == S_LOW || state_q == S_HIGH) && (cnt_q == '0);
      arr_wdata = arr_hi ? wdata_q[WORD_W-1:HALF_W] : wdata_q[HALF_W-1:0];
   end

   sram_half_array #(
      .DEPTH (2 * MEM_WORDS)
   ) u_array (
      .clk     (clk),
      .en_i    (arr_en),
      .we_i    (op_wr_q),
      .addr_i  ({idx_q, arr_hi}),
      .wdata_i (arr_wdata),
      .rdata_o (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_wr_q     <= 1'b0;
         err_q       <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         lo_hold_q   <= '0;
         read_data_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rd_en || wr_en) begin
                  op_wr_q <= wr_en;
                  idx_q   <= word_off[IDX_W-1:0];
                  wdata_q <= write_data;
                  cnt_q   <= CNT_LOAD;
                  err_q   <= reject;
                  state_q <= reject ? S_DONE : S_LOW;
               end
            end
            S_LOW: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  cnt_q   <= CNT_LOAD;
                  state_q <= S_HIGH;
               end
            end
            S_HIGH: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  // Low-half read result is still in the array register; save it
                  // before the high-half read replaces it on this edge.
                  lo_hold_q <= arr_rdata;
                  state_q   <= S_DONE;
               end
            end
            default: begin
               if (!op_wr_q && !err_q) begin
                  read_data_q <= {arr_rdata, lo_hold_q};
               end
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // The assembled word is visible from the DONE cycle onwards.
   assign read_data = (state_q == S_DONE && !op_wr_q && !err_q) ? {arr_rdata, lo_hold_q}
                                                                 : read_data_q;
   assign ready     = (state_q == S_DONE);
   assign error     = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: default build (index 0) and WAIT_CYCLES=0 build (index 1)
// driven by directed and random requests, checked against a half-word memory model.
module tb_sram_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst        [2];
   logic        rd_en      [2];
   logic        wr_en      [2];
   logic [31:0] address    [2];
   logic [31:0] write_data [2];
   logic [31:0] read_data  [2];
   logic        ready      [2];
   logic        error      [2];

   sram_responder u_dut_w2 (
      .clk        (clk),
      .rst        (rst[0]),
      .rd_en      (rd_en[0]),
      .wr_en      (wr_en[0]),
      .address    (address[0]),
      .write_data (write_data[0]),
      .read_data  (read_data[0]),
      .ready      (ready[0]),
      .error      (error[0])
   );

   sram_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
      .clk        (clk),
      .rst        (rst[1]),
      .rd_en      (rd_en[1]),
      .wr_en      (wr_en[1]),
      .address    (address[1]),
      .write_data (write_data[1]),
      .read_data  (read_data[1]),
      .ready      (ready[1]),
      .error      (error[1])
   );

   int          vectors     = 0;
   int          miscompares = 0;

   // Reference model: memory as separately-known halves, plus last read word.
   logic [15:0] m_lo   [2][64];
   logic [15:0] m_hi   [2][64];
   bit          v_lo   [2][64];
   bit          v_hi   [2][64];
   logic [31:0] m_rd   [2];
   bit          rd_known [2];

   function automatic int waits(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic bit rejects(input bit rd, input bit wr, input logic [31:0] a);
      if (rd && wr) return 1'b1;
      if (a < 32'd1024) return 1'b1;
      if (a % 4 != 0) return 1'b1;
      if ((a - 32'd1024) / 4 >= 64) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request on DUT d; abort_c >= 0 asserts rst for the edge abort_c+1 edges after sampling.
   task automatic request(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int abort_c);
      bit rej;
      int lat;
      int c;
      int idx;
      int seen;
      rej = rejects(rd, wr, a);
      lat = rej ? 0 : 2 * waits(d) + 2;
      idx = int'((a - 32'd1024) / 4);
      rd_en[d] = rd; wr_en[d] = wr; address[d] = a; write_data[d] = wd;
      @(posedge clk); #1;
      if (abort_c >= 0) begin
         seen = 0;
         for (int k = 0; k < 12; k++) begin
            if (ready[d]) seen++;
            if (k == abort_c) begin
               rst[d] = 1'b1; rd_en[d] = 1'b0; wr_en[d] = 1'b0;
            end else begin
               rst[d] = 1'b0;
            end
            @(posedge clk); #1;
         end
         rst[d] = 1'b0;
         check("abort_no_ready", 32'(seen), 32'd0);
         if (wr && !rej) begin
            if (abort_c > waits(d)) begin
               m_lo[d][idx] = wd[15:0]; v_lo[d][idx] = 1'b1;
            end
            if (abort_c > 2 * waits(d) + 1) begin
               m_hi[d][idx] = wd[31:16]; v_hi[d][idx] = 1'b1;
            end
         end
         m_rd[d] = 32'h0; rd_known[d] = 1'b1;
         check("abort_read_data", read_data[d], 32'h0);
         return;
      end
      c = 0;
      while (!ready[d] && c < 40) begin
         @(posedge clk); #1;
         c++;
      end
      check(rej ? "reject_latency" : "latency", 32'(c), 32'(lat));
      check("error", 32'(error[d]), 32'(rej));
      if (!rej) begin
         if (wr) begin
            m_lo[d][idx] = wd[15:0];  v_lo[d][idx] = 1'b1;
            m_hi[d][idx] = wd[31:16]; v_hi[d][idx] = 1'b1;
         end else begin
            rd_known[d] = v_lo[d][idx] && v_hi[d][idx];
            m_rd[d] = {m_hi[d][idx], m_lo[d][idx]};
         end
      end
      if (rd_known[d]) check("read_data", read_data[d], m_rd[d]);
      rd_en[d] = 1'b0; wr_en[d] = 1'b0;
      @(posedge clk); #1;
      check("ready_one_cycle", 32'(ready[d]), 32'd0);
   endtask

   task automatic random_requests(input int d, input int n);
      logic [31:0] bad [7];
      int          r;
      int          idx;
      bad = '{32'd1020, 32'd1026, 32'd1280, 32'd0, 32'hFFFF_FFFC, 32'd1284, 32'd1027};
      for (int i = 0; i < n; i++) begin
         r   = $urandom_range(0, 9);
         idx = $urandom_range(0, 15);
         if (r == 0) begin
            request(d, 1'b1, 1'b0, bad[$urandom_range(0, 6)], $urandom, -1);
         end else if (r == 1) begin
            request(d, 1'b1, 1'b1, 32'd1024 + 32'(idx) * 4, $urandom, -1);
         end else if (r < 6 && v_lo[d][idx] && v_hi[d][idx]) begin
            request(d, 1'b1, 1'b0, 32'd1024 + 32'(idx) * 4, 32'h0, -1);
         end else begin
            request(d, 1'b0, 1'b1, 32'd1024 + 32'(idx) * 4, $urandom, -1);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; rd_en[d] = 1'b1; wr_en[d] = 1'b0;
         address[d] = 32'd1024; write_data[d] = 32'h0;
         m_rd[d] = 32'h0; rd_known[d] = 1'b1;
         for (int i = 0; i < 64; i++) begin
            v_lo[d][i] = 1'b0; v_hi[d][i] = 1'b0;
         end
      end

      // Reset held two cycles with a read request pending.
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            check("reset_ready", 32'(ready[d]), 32'd0);
            check("reset_error", 32'(error[d]), 32'd0);
            check("reset_read_data", read_data[d], 32'h0);
         end
      end
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; rd_en[d] = 1'b0;
      end
      @(posedge clk); #1;

      // Default build: write/read, back-to-back, rejections, aborted write.
      request(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, -1);
      request(0, 1'b1, 1'b0, 32'd1024, 32'h0, -1);
      request(0, 1'b0, 1'b1, 32'd1028, 32'h12345678, -1);
      request(0, 1'b1, 1'b0, 32'd1028, 32'h0, -1);
      request(0, 1'b1, 1'b0, 32'd1024, 32'h0, -1);
      request(0, 1'b1, 1'b0, 32'd1020, 32'h0, -1);
      request(0, 1'b1, 1'b0, 32'd1026, 32'h0, -1);
      request(0, 1'b0, 1'b1, 32'd1280, 32'h11111111, -1);
      request(0, 1'b1, 1'b1, 32'd1024, 32'h22222222, -1);
      request(0, 1'b1, 1'b0, 32'd1024, 32'h0, -1);
      request(0, 1'b0, 1'b1, 32'd1032, 32'h0, -1);
      request(0, 1'b0, 1'b1, 32'd1032, 32'hAAAA5555, 3);
      request(0, 1'b1, 1'b0, 32'd1032, 32'h0, -1);
      check("abort_partial_write", m_rd[0], 32'h00005555);

      // Zero-wait build.
      request(1, 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, -1);
      request(1, 1'b1, 1'b0, 32'd1024, 32'h0, -1);
      request(1, 1'b1, 1'b0, 32'd1276, 32'h0, -1);
      request(1, 1'b0, 1'b1, 32'd1276, 32'h0BADF00D, -1);
      request(1, 1'b1, 1'b0, 32'd1276, 32'h0, -1);

      random_requests(0, 40);
      random_requests(1, 40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
